seq_buffer: RTL and testbench
=============================

SEQ_BUFFER -- requirements
Module: seq_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 6: bits per stored entry.
REQ-002 SHALL have parameter DEPTH, default 30: number of entries, DEPTH >= 2.
REQ-003 SHALL derive localparams AW = $clog2(DEPTH) (pointer width) and LW = $clog2(DEPTH+1) (length width).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clr  input  1  synchronous clear of the stored sequence.
REQ-007 SHALL have port rewind  input  1  return playback and check pointers to entry 0.
REQ-008 SHALL have port wr_en  input  1  append wr_data at the tail.
REQ-009 SHALL have port wr_data  input  WIDTH  entry to append.
REQ-010 SHALL have port rd_en  input  1  read the entry at the playback pointer and advance it.
REQ-011 SHALL have port chk_en  input  1  compare chk_data with the entry at the check pointer and advance it.
REQ-012 SHALL have port chk_data  input  WIDTH  value to compare.
REQ-013 SHALL have port rd_data  output  WIDTH  registered playback entry.
REQ-014 SHALL have port rd_valid  output  1  rd_data/rd_idx/rd_last valid this cycle.
REQ-015 SHALL have port rd_idx  output  AW  index of the entry in rd_data.
REQ-016 SHALL have port rd_last  output  1  rd_data is the final stored entry.
REQ-017 SHALL have port chk_hit  output  1  one-cycle pulse: compared value matched.
REQ-018 SHALL have port chk_miss  output  1  one-cycle pulse: mismatch, or check past the end.
REQ-019 SHALL have port chk_done  output  1  one-cycle pulse: match on the final stored entry.
REQ-020 SHALL have port len  output  LW  number of stored entries.
REQ-021 SHALL have ports full / empty  output  1  len==DEPTH / len==0, combinational from len.
REQ-022 SHALL have port wr_err  output  1  one-cycle pulse: write attempted while full.

Function
REQ-023 Storage SHALL be a DEPTH x WIDTH array; contents are not reset and not cleared by clr.
REQ-024 wr_en with len<DEPTH SHALL write mem[len]<=wr_data and set len<=len+1.
REQ-025 wr_en with len==DEPTH SHALL leave mem and len unchanged and pulse wr_err the next cycle.
REQ-026 rd_en with rd_ptr<len SHALL, next cycle, present rd_data=mem[rd_ptr], rd_idx=rd_ptr, rd_valid=1, rd_last=(rd_ptr==len-1), and increment rd_ptr (1-cycle latency).
REQ-027 rd_en with rd_ptr>=len SHALL give rd_valid=0 next cycle and leave rd_ptr unchanged.
REQ-028 rd_valid SHALL be 0 in every cycle not following an accepted rd_en; rd_data/rd_idx hold their last value.
REQ-029 chk_en with chk_ptr<len SHALL compare chk_data to mem[chk_ptr]: on match pulse chk_hit next cycle and increment chk_ptr; also pulse chk_done if chk_ptr==len-1.
REQ-030 On mismatch chk_en SHALL pulse chk_miss next cycle and leave chk_ptr unchanged.
REQ-031 chk_en with chk_ptr>=len SHALL pulse chk_miss next cycle.
REQ-032 rd_en, chk_en and wr_en SHALL all be serviced in the same cycle; read and check use the pre-write len, so same-cycle append is invisible to them (no bypass).
REQ-033 rewind SHALL set rd_ptr<=0 and chk_ptr<=0; it has priority over rd_en/chk_en in that cycle (no read, no check, outputs treated as idle).
REQ-034 clr SHALL set len<=0, rd_ptr<=0, chk_ptr<=0 and force idle outputs next cycle; it has priority over wr_en, rd_en, chk_en and rewind.
REQ-035 Pointers SHALL never wrap; len saturates at DEPTH.

Reset
REQ-036 rst_n low SHALL immediately force len=0, rd_ptr=0, chk_ptr=0, rd_valid=0, rd_last=0, rd_idx=0, rd_data=0, chk_hit=chk_miss=chk_done=0, wr_err=0; empty=1, full=0.
REQ-037 Reset asserted mid-operation SHALL discard any in-flight read/check result; the first cycle after release is idle.

Verification
REQ-038 Append 3,5,1 then rewind, rd_en x4 -> rd_data 3,5,1 with rd_idx 0,1,2, rd_last only on the third; fourth gives rd_valid=0.
REQ-039 Write DEPTH=30 entries, then a 31st -> full=1, len=30, wr_err pulses once, mem[29] unchanged.
REQ-040 Sequence 2,4; chk 2,7,4 -> chk_hit, chk_miss, chk_hit+chk_done; an extra chk -> chk_miss.
REQ-041 len=2; same cycle wr_en(9)+rd_en at rd_ptr=2 -> rd_valid=0, len=3; next rd_en -> rd_data=9, rd_last=1.
REQ-042 clr asserted together with wr_en and rd_en -> len=0, empty=1, rd_valid=0; the stored array is untouched.
REQ-043 rst_n pulsed low during a playback sequence -> all outputs at reset values asynchronously; rd_valid=0 in the first cycle after release.

Source files
------------

// File: rtl/seq_buffer.sv
// Record-and-replay sequence store: entries are appended at the tail, then
// read back in order (playback) and/or compared in order against expected data (check).
module seq_buffer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 30,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             rewind,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             chk_en,
  input  logic [WIDTH-1:0] chk_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW-1:0]    rd_idx,
  output logic             rd_last,
  output logic             chk_hit,
  output logic             chk_miss,
  output logic             chk_done,
  output logic [LW-1:0]    len,
  output logic             full,
  output logic             empty,
  output logic             wr_err
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers are LW wide so they can sit at len (one past the last entry).
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    chk_ptr_q, chk_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic             chk_hit_q, chk_hit_d;
  logic             chk_miss_q, chk_miss_d;
  logic             chk_done_q, chk_done_d;
  logic             wr_err_q, wr_err_d;
  logic             mem_we;

  logic [LW-1:0]    last_idx;
  logic             rd_in_range;
  logic             chk_in_range;
  logic             has_room;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] chk_word;

  assign last_idx     = len_q - LW'(1);
  assign rd_in_range  = rd_ptr_q < len_q;
  assign chk_in_range = chk_ptr_q < len_q;
  assign has_room     = len_q < LW'(DEPTH);
  assign rd_word      = mem[rd_ptr_q[AW-1:0]];
  assign chk_word     = mem[chk_ptr_q[AW-1:0]];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    chk_ptr_d  = chk_ptr_q;
    rd_data_d  = rd_data_q;
    rd_idx_d   = rd_idx_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    chk_hit_d  = 1'b0;
    chk_miss_d = 1'b0;
    chk_done_d = 1'b0;
    wr_err_d   = 1'b0;
    mem_we     = 1'b0;

    if (clr) begin
      len_d     = '0;
      rd_ptr_d  = '0;
      chk_ptr_d = '0;
    end else begin
      if (rewind) begin
        rd_ptr_d  = '0;
        chk_ptr_d = '0;
      end else begin
        if (rd_en && rd_in_range) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_word;
          rd_idx_d   = rd_ptr_q[AW-1:0];
          rd_last_d  = (rd_ptr_q == last_idx);
          rd_ptr_d   = rd_ptr_q + LW'(1);
        end

        if (chk_en) begin
          if (chk_in_range && (chk_data == chk_word)) begin
            chk_hit_d  = 1'b1;
            chk_done_d = (chk_ptr_q == last_idx);
            chk_ptr_d  = chk_ptr_q + LW'(1);
          end else begin
            chk_miss_d = 1'b1;
          end
        end
      end

      // Read and check above used the pre-write len: a same-cycle append
      // becomes visible only from the next cycle.
      if (wr_en) begin
        if (has_room) begin
          mem_we = 1'b1;
          len_d  = len_q + LW'(1);
        end else begin
          wr_err_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      rd_ptr_q   <= '0;
      chk_ptr_q  <= '0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      chk_hit_q  <= 1'b0;
      chk_miss_q <= 1'b0;
      chk_done_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      chk_ptr_q  <= chk_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      chk_hit_q  <= chk_hit_d;
      chk_miss_q <= chk_miss_d;
      chk_done_q <= chk_done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // NOTE: the storage array has no reset; entries beyond len are never
  // observable, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[len_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_idx   = rd_idx_q;
  assign rd_last  = rd_last_q;
  assign chk_hit  = chk_hit_q;
  assign chk_miss = chk_miss_q;
  assign chk_done = chk_done_q;
  assign len      = len_q;
  assign full     = (len_q == LW'(DEPTH));
  assign empty    = (len_q == '0);
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_seq_buffer.sv
// Self-checking bench for seq_buffer: directed scenarios plus a randomized run
// compared against a queue-based model of the stored sequence.
module tb_seq_buffer;

  localparam int WIDTH = 6;
  localparam int DEPTH = 30;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             rewind;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             chk_en;
  logic [WIDTH-1:0] chk_data;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [AW-1:0]    rd_idx;
  logic             rd_last;
  logic             chk_hit;
  logic             chk_miss;
  logic             chk_done;
  logic [LW-1:0]    len;
  logic             full;
  logic             empty;
  logic             wr_err;

  int total = 0;
  int bad   = 0;

  // Reference model: the stored sequence as a queue plus two plain indices.
  int seq [$];
  int m_rp, m_cp;
  int e_rd_data, e_rd_idx;
  bit e_rd_valid, e_rd_last, e_hit, e_miss, e_done, e_wr_err;

  seq_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rewind(rewind),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .chk_en(chk_en), .chk_data(chk_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_last(rd_last),
    .chk_hit(chk_hit), .chk_miss(chk_miss), .chk_done(chk_done),
    .len(len), .full(full), .empty(empty), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    seq.delete();
    m_rp = 0; m_cp = 0;
    e_rd_data = 0; e_rd_idx = 0;
    e_rd_valid = 0; e_rd_last = 0; e_hit = 0; e_miss = 0; e_done = 0; e_wr_err = 0;
  endtask

  // Applies one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic drive(input bit c, input bit rw, input bit w, input int wd,
                       input bit r, input bit ch, input int cd);
    int n;
    clr = c; rewind = rw; wr_en = w; wr_data = WIDTH'(wd);
    rd_en = r; chk_en = ch; chk_data = WIDTH'(cd);
    n = seq.size();
    e_rd_valid = 0; e_rd_last = 0; e_hit = 0; e_miss = 0; e_done = 0; e_wr_err = 0;
    if (c) begin
      seq.delete(); m_rp = 0; m_cp = 0;
    end else begin
      if (rw) begin
        m_rp = 0; m_cp = 0;
      end else begin
        if (r && m_rp < n) begin
          e_rd_valid = 1; e_rd_data = seq[m_rp]; e_rd_idx = m_rp;
          e_rd_last = (m_rp == n - 1); m_rp++;
        end
        if (ch) begin
          if (m_cp < n && (cd % 64) == seq[m_cp]) begin
            e_hit = 1; e_done = (m_cp == n - 1); m_cp++;
          end else begin
            e_miss = 1;
          end
        end
      end
      if (w) begin
        if (n < DEPTH) seq.push_back(wd % 64);
        else e_wr_err = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    total++;
    if ({rd_valid, rd_last, rd_idx, rd_data, chk_hit, chk_miss, chk_done, wr_err, len, full, empty}
        !== {1'b0, 1'b0, AW'(0), WIDTH'(0), 4'b0, LW'(0), 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_values: got valid=%0b last=%0b idx=%0d data=%0d hit=%0b miss=%0b done=%0b err=%0b len=%0d full=%0b empty=%0b, want all 0 with empty=1",
               rd_valid, rd_last, rd_idx, rd_data, chk_hit, chk_miss, chk_done, wr_err, len, full, empty);
    end
  endtask

  task automatic test_playback();
    int vals [3] = '{3, 5, 1};
    drive(1, 0, 0, 0, 0, 0, 0);
    foreach (vals[i]) drive(0, 0, 1, vals[i], 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      total++;
      if ({rd_valid, rd_data, rd_idx, rd_last} !== {1'b1, WIDTH'(vals[i]), AW'(i), (i == 2)}) begin
        bad++;
        $display("FAIL playback_%0d: got valid=%0b data=%0d idx=%0d last=%0b, want valid=1 data=%0d idx=%0d last=%0b",
                 i, rd_valid, rd_data, rd_idx, rd_last, vals[i], i, (i == 2));
      end
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL playback_past_end: got rd_valid=%0b, want 0", rd_valid);
    end
  endtask

  task automatic test_full();
    int v29;
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, (i * 7 + 3) % 64, 0, 0, 0);
      if (i == DEPTH - 2) begin
        total++;
        if (full !== 1'b0) begin
          bad++;
          $display("FAIL not_full_at_29: got full=%0b, want 0", full);
        end
      end
    end
    v29 = ((DEPTH - 1) * 7 + 3) % 64;
    total++;
    if ({full, len, wr_err} !== {1'b1, LW'(DEPTH), 1'b0}) begin
      bad++;
      $display("FAIL full_at_30: got full=%0b len=%0d wr_err=%0b, want 1 30 0", full, len, wr_err);
    end
    drive(0, 0, 1, (~v29) & 63, 0, 0, 0);
    total++;
    if ({wr_err, len, full} !== {1'b1, LW'(DEPTH), 1'b1}) begin
      bad++;
      $display("FAIL overflow_write: got wr_err=%0b len=%0d full=%0b, want 1 30 1", wr_err, len, full);
    end
    idle();
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_err_single_pulse: got wr_err=%0b, want 0", wr_err);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 1, 0, 0);
    total++;
    if ({rd_valid, rd_data, rd_idx, rd_last} !== {1'b1, WIDTH'(v29), AW'(DEPTH - 1), 1'b1}) begin
      bad++;
      $display("FAIL entry29_kept: got valid=%0b data=%0d idx=%0d last=%0b, want 1 %0d 29 1",
               rd_valid, rd_data, rd_idx, rd_last, v29);
    end
  endtask

  task automatic test_check();
    int cv [4] = '{2, 7, 4, 4};
    bit [2:0] want [4] = '{3'b100, 3'b010, 3'b101, 3'b010};
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 2, 0, 0, 0);
    drive(0, 0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, cv[i]);
      total++;
      if ({chk_hit, chk_miss, chk_done} !== want[i]) begin
        bad++;
        $display("FAIL check_%0d: got hit/miss/done=%03b, want %03b", i, {chk_hit, chk_miss, chk_done}, want[i]);
      end
    end
    idle();
    total++;
    if ({chk_hit, chk_miss, chk_done} !== 3'b000) begin
      bad++;
      $display("FAIL check_idle: got hit/miss/done=%03b, want 000", {chk_hit, chk_miss, chk_done});
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 11, 0, 0, 0);
    drive(0, 0, 1, 22, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 9, 1, 0, 0);
    total++;
    if ({rd_valid, len} !== {1'b0, LW'(3)}) begin
      bad++;
      $display("FAIL same_cycle_write_read: got rd_valid=%0b len=%0d, want 0 3", rd_valid, len);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    total++;
    if ({rd_valid, rd_data, rd_idx, rd_last} !== {1'b1, WIDTH'(9), AW'(2), 1'b1}) begin
      bad++;
      $display("FAIL read_after_append: got valid=%0b data=%0d idx=%0d last=%0b, want 1 9 2 1",
               rd_valid, rd_data, rd_idx, rd_last);
    end
  endtask

  task automatic test_clr();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 40 + i, 0, 0, 0);
    drive(1, 1, 1, 5, 1, 1, 40);
    total++;
    if ({len, empty, rd_valid, chk_hit, chk_miss, wr_err} !== {LW'(0), 1'b1, 4'b0}) begin
      bad++;
      $display("FAIL clr_priority: got len=%0d empty=%0b rd_valid=%0b hit=%0b miss=%0b wr_err=%0b, want 0 1 0 0 0 0",
               len, empty, rd_valid, chk_hit, chk_miss, wr_err);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 20 + i, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 20);
    rd_en = 1'b1; chk_en = 1'b1; chk_data = 6'd21;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({rd_valid, rd_last, rd_idx, rd_data, chk_hit, chk_miss, chk_done, wr_err, len, full, empty}
        !== {1'b0, 1'b0, AW'(0), WIDTH'(0), 4'b0, LW'(0), 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset: got valid=%0b idx=%0d data=%0d hit=%0b len=%0d empty=%0b, want all 0 with empty=1",
               rd_valid, rd_idx, rd_data, chk_hit, len, empty);
    end
    rd_en = 1'b0; chk_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({rd_valid, chk_hit, chk_miss} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_release: got rd_valid=%0b hit=%0b miss=%0b, want 0 0 0", rd_valid, chk_hit, chk_miss);
    end
  endtask

  task automatic test_random();
    logic [23:0] act, exp_v;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit c, rw, w, r, ch;
      int wd, cd;
      c  = ($urandom_range(99) < 2);
      rw = ($urandom_range(99) < 4);
      w  = ($urandom_range(99) < 45);
      r  = ($urandom_range(99) < 40);
      ch = ($urandom_range(99) < 40);
      wd = $urandom_range(63);
      if (m_cp < seq.size() && $urandom_range(3) != 0) cd = seq[m_cp];
      else cd = $urandom_range(63);
      drive(c, rw, w, wd, r, ch, cd);
      act   = {rd_valid, rd_data, rd_idx, rd_last & rd_valid, chk_hit, chk_miss, chk_done,
               len, full, empty, wr_err};
      exp_v = {e_rd_valid, WIDTH'(e_rd_data), AW'(e_rd_idx), e_rd_last, e_hit, e_miss, e_done,
               LW'(seq.size()), (seq.size() == DEPTH), (seq.size() == 0), e_wr_err};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL random_cycle_%0d: got %06h, want %06h (valid,data,idx,last,hit,miss,done,len,full,empty,err)",
                 cyc, act, exp_v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 0; rewind = 0; wr_en = 0; wr_data = '0; rd_en = 0; chk_en = 0; chk_data = '0;
    model_reset();
    #2;
    test_reset();
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_playback();
    test_full();
    test_check();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
